// File: rtl/dsp_mac_seq.sv
// Streams signed A/B terms into a DSP48A1 multiply-accumulate and captures P as the result.
// Defining DSP_MAC_SEQ_ABORT_EN adds an abort input that cancels an accumulation in progress.
module dsp_mac_seq #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 4,
    parameter int OPM_DLY  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p,
    output logic [47:0]      res,
    output logic             res_valid,
    input  logic             res_ready
`ifdef DSP_MAC_SEQ_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [7:0] OPM_MUL  = 8'h01;
    localparam logic [7:0] OPM_MAC  = 8'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, cnt_q;
    logic [3:0]             drn_q;
    logic [OPM_DLY:0][7:0]  opm_pipe;
    logic                   accept, last_term, drain_end, kill;

    assign accept    = (state_q == ACCUM) && in_valid;
    assign last_term = accept && (cnt_q == len_q - LEN_W'(1));
    assign drain_end = (state_q == DRAIN) && (drn_q == 4'(PIPE_LAT - 1));

`ifdef DSP_MAC_SEQ_ABORT_EN
    assign kill = abort && ((state_q == ACCUM) || (state_q == DRAIN));
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        in_ready  = (state_q == ACCUM);
        dsp_ce    = (state_q == ACCUM) || (state_q == DRAIN);
        res_valid = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (start) state_d = (len == '0) ? DONE : ACCUM;
            ACCUM:   if (last_term) state_d = DRAIN;
            DRAIN:   if (drain_end) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            res     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                len_q <= len;
                cnt_q <= '0;
            end
            if (accept) cnt_q <= cnt_q + LEN_W'(1);
            // drn_q counts cycles since the last issue; P is valid on its final count
            drn_q <= (state_q == DRAIN && !drain_end) ? drn_q + 4'd1 : 4'd0;
            if (state_q == IDLE && start && len == '0) res <= '0;
            if (drain_end && !kill) res <= dsp_p;
        end
    end

    // opm_pipe[0] is aligned with dsp_a/dsp_b; later taps delay it toward the DSP OPMODE port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsp_a    <= '0;
            dsp_b    <= '0;
            opm_pipe <= '0;
        end else if (kill) begin
            dsp_a    <= '0;
            dsp_b    <= '0;
            opm_pipe <= '0;
        end else begin
            for (int k = OPM_DLY; k > 0; k--) opm_pipe[k] <= opm_pipe[k-1];
            if (accept) begin
                dsp_a       <= in_a;
                dsp_b       <= in_b;
                opm_pipe[0] <= (cnt_q == '0) ? OPM_MUL : OPM_MAC;
            end else begin
                dsp_a       <= '0;
                dsp_b       <= '0;
                opm_pipe[0] <= dsp_ce ? OPM_HOLD : 8'h00;
            end
        end
    end

    assign dsp_opmode = opm_pipe[OPM_DLY];

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq; a small DSP48A1 model turns dsp_a/dsp_b/dsp_opmode into dsp_p.
module tb_dsp_mac_seq;
    localparam int PIPE_LAT = 4;
    localparam int OPM_DLY  = 2;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
    logic [7:0]  len = '0;
    logic [17:0] in_a = '0, in_b = '0;
    logic        busy, in_ready, dsp_ce, res_valid;
    logic [17:0] dsp_a, dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p, res;
`ifdef DSP_MAC_SEQ_ABORT_EN
    logic        abort = 1'b0;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, ce_cnt = 0;
    logic [7:0] opm_log[$];
    logic signed [17:0] qa[$], qb[$];

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][17:0] a;
        logic [3:0][17:0] b;
        logic [47:0]      exp;
    } vec_t;

    dsp_mac_seq #(.LEN_W(8), .PIPE_LAT(PIPE_LAT), .OPM_DLY(OPM_DLY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
        .dsp_p(dsp_p), .res(res), .res_valid(res_valid), .res_ready(res_ready)
`ifdef DSP_MAC_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // DSP48A1 with A/B, M and P stages: product meets its OPMODE OPM_DLY cycles after issue
    longint prod_d1 = 0, prod_d2 = 0, p_acc = 0;
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ce_cnt <= ce_cnt + (dsp_ce ? 1 : 0);
        opm_log.push_back(dsp_opmode);
        if (dsp_ce) begin
            prod_d1 <= longint'($signed(dsp_a)) * longint'($signed(dsp_b));
            prod_d2 <= prod_d1;
            case (dsp_opmode)
                8'h01:   p_acc <= prod_d2;
                8'h09:   p_acc <= p_acc + prod_d2;
                8'h08:   p_acc <= p_acc;
                default: p_acc <= 0;
            endcase
        end
    end
    assign dsp_p = p_acc[47:0];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input int a0, b0, a1, b1, a2, b2, a3, b3,
                                input longint e);
        vec_t v;
        v.n = 3'(n);
        v.a[0] = 18'(a0); v.b[0] = 18'(b0); v.a[1] = 18'(a1); v.b[1] = 18'(b1);
        v.a[2] = 18'(a2); v.b[2] = 18'(b2); v.a[3] = 18'(a3); v.b[3] = 18'(b3);
        v.exp = e[47:0];
        return v;
    endfunction

    function automatic longint ref_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(qa[i]) * longint'(qb[i]);
        return s;
    endfunction

    task automatic clr();
        qa.delete();
        qb.delete();
    endtask

    task automatic add(input int a, input int b);
        qa.push_back(18'(a));
        qb.push_back(18'(b));
    endtask

    task automatic kick(input int n);
        start = 1'b1;
        len = 8'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_term(input logic signed [17:0] a, input logic signed [17:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
    endtask

    task automatic feed(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            send_term(qa[i], qb[i]);
        end
    endtask

    task automatic wait_res(input string name, input int acc_cyc, output logic [47:0] r);
        int t = 0;
        while (!res_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_lat"}, 64'(cyc - acc_cyc), 64'(PIPE_LAT));
        r = res;
    endtask

    task automatic release_res(input int dly);
        repeat (dly) @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after_ready", 64'({res_valid, busy}), 64'd0);
    endtask

    task automatic job(input string name, input int n, input int gap, input int dly,
                       input longint exp);
        logic [47:0] r;
        int acc;
        kick(n);
        feed(n, gap);
        acc = cyc;
        wait_res(name, acc, r);
        chk({name, "_res"}, 64'(r), 64'(exp[47:0]));
        release_res(dly);
    endtask

    initial begin
        vec_t tbl[5];
        logic [7:0] bub_exp[6];
        logic [47:0] r;
        int acc, c0, idx0, p, vseen;

        tbl[0] = mk(3, 2, 3, 4, 5, -1, 6, 0, 0, 64'sd20);
        tbl[1] = mk(1, 7, 7, 0, 0, 0, 0, 0, 0, 64'sd49);
        tbl[2] = mk(2, -100, 200, 50, -3, 0, 0, 0, 0, -64'sd20150);
        tbl[3] = mk(4, 131071, 131071, 131071, 131071, 131071, 131071, 131071, 131071,
                    64'sd68718428164);
        tbl[4] = mk(2, -131072, -131072, -131072, 131071, 0, 0, 0, 0, 64'sd131072);
        bub_exp = '{8'h01, 8'h09, 8'h08, 8'h08, 8'h09, 8'h09};

        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({busy, in_ready, res_valid, dsp_ce}), 64'd0);
        chk("rst_data", 64'({dsp_a, dsp_b, dsp_opmode}), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            clr();
            for (int k = 0; k < int'(tbl[i].n); k++) add(int'($signed(tbl[i].a[k])), int'($signed(tbl[i].b[k])));
            job($sformatf("tbl%0d", i), int'(tbl[i].n), 0, i % 3, longint'($signed(tbl[i].exp)));
        end

        // zero-length job: immediate DONE with res cleared, DSP never enabled
        c0 = ce_cnt;
        kick(0);
        chk("len0_valid", 64'(res_valid), 64'd1);
        chk("len0_res", 64'(res), 64'd0);
        release_res(1);
        chk("len0_ce", 64'(ce_cnt - c0), 64'd0);

        // two bubbles between terms 2 and 3
        clr();
        idx0 = opm_log.size();
        kick(4);
        send_term(1, 1);
        send_term(1, 1);
        repeat (2) @(negedge clk);
        send_term(1, 1);
        send_term(1, 1);
        acc = cyc;
        wait_res("bub", acc, r);
        chk("bub_res", 64'(r), 64'd4);
        release_res(0);
        p = -1;
        for (int i = idx0; i < opm_log.size(); i++) if (p < 0 && opm_log[i] == 8'h01) p = i;
        chk("bub_first_mul", 64'(p >= 0), 64'd1);
        for (int k = 0; k < 6; k++)
            chk($sformatf("bub_opm%0d", k),
                64'((p >= 0 && p + k < opm_log.size()) ? opm_log[p + k] : 8'hee), 64'(bub_exp[k]));

        // hold in DONE with a stray start, then start coinciding with res_ready
        kick(1);
        send_term(5, 5);
        acc = cyc;
        wait_res("hold", acc, r);
        chk("hold_first", 64'(r), 64'd25);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len = 8'd3;
            @(negedge clk);
            chk("hold_res", 64'(res), 64'd25);
            chk("hold_valid", 64'(res_valid), 64'd1);
        end
        start = 1'b0;
        res_ready = 1'b1;
        start = 1'b1;
        len = 8'd2;
        @(negedge clk);
        res_ready = 1'b0;
        chk("start_with_ready_ignored", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        chk("start_after_done", 64'({busy, in_ready}), 64'd3);
        clr();
        add(3, 10);
        add(-4, 10);
        feed(2, 0);
        acc = cyc;
        wait_res("after_done", acc, r);
        chk("after_done_res", 64'(r), 64'(48'hffff_ffff_fff6));
        release_res(0);

        // reset in the middle of DRAIN
        clr();
        add(100, 9);
        add(-7, 9);
        kick(2);
        feed(2, 0);
        @(negedge clk);
        chk("drain_state", 64'({busy, in_ready, dsp_ce}), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 64'({busy, in_ready, res_valid, dsp_ce}), 64'd0);
        chk("mid_rst_data", 64'({dsp_a, dsp_b, dsp_opmode}), 64'd0);
        chk("mid_rst_res", 64'(res), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr();
        add(7, 7);
        job("post_rst", 1, 0, 0, 64'sd49);

`ifdef DSP_MAC_SEQ_ABORT_EN
        clr();
        kick(3);
        send_term(11, 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ctrl", 64'({busy, res_valid, dsp_ce}), 64'd0);
        chk("abort_opm", 64'(dsp_opmode), 64'd0);
        vseen = 0;
        repeat (PIPE_LAT + 2) begin
            @(negedge clk);
            if (res_valid || busy) vseen++;
        end
        chk("abort_quiet", 64'(vseen), 64'd0);
        clr();
        add(3, 3);
        job("post_abort", 1, 0, 0, 64'sd9);
`endif

        // longest job: counter must reach len-1 without wrapping
        clr();
        for (int i = 0; i < 255; i++) add(int'($signed(18'($urandom))), int'($signed(18'($urandom))));
        job("len255", 255, 0, 0, ref_sum(255));

        for (int j = 0; j < 25; j++) begin
            int n;
            n = $urandom_range(8, 1);
            clr();
            for (int i = 0; i < n; i++)
                add(int'($signed(18'($urandom))), int'($signed(18'($urandom))));
            job($sformatf("rnd%0d", j), n, 2, $urandom_range(3, 0), ref_sum(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
